// File: rtl/instruction_decode_pkg.sv
// instruction_decode_pkg: shared widths, MIPS opcode/funct encodings and register names for the decode stage
package instruction_decode_pkg;
    localparam int IWIDTH   = 32;
    localparam int PC_WIDTH = 32;
    localparam int DWIDTH   = 32;
    localparam int AWIDTH   = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;
    localparam logic [4:0] REG_RA   = 5'd31;
endpackage

// File: rtl/instruction_decode_register_file.sv
// register_file: 32-entry register file, two combinational read ports with write-back bypass
// Ports:
//   clk_i, rst_ni              clock, async active-low reset (clears every register)
//   we_i, waddr_i, wdata_i     synchronous write port; writes to register 0 are dropped
//   raddr_a_i / rdata_a_o      read port A
//   raddr_b_i / rdata_b_o      read port B
module register_file #(
    parameter int DWIDTH = instruction_decode_pkg::DWIDTH,
    parameter int AWIDTH = instruction_decode_pkg::AWIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_a_i,
    input  logic [AWIDTH-1:0] raddr_b_i,
    output logic [DWIDTH-1:0] rdata_a_o,
    output logic [DWIDTH-1:0] rdata_b_o
);
    logic [DWIDTH-1:0] mem_q [1<<AWIDTH];

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            for (int i = 0; i < (1 << AWIDTH); i++) mem_q[i] <= '0;
        else if (we_i && waddr_i != '0)
            mem_q[waddr_i] <= wdata_i;

    // A same-cycle write to the addressed register is forwarded so decode sees the new value.
    assign rdata_a_o = (raddr_a_i == '0) ? '0 : (we_i && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : (we_i && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: MIPS decode stage; field/control decode, operand read, load-use stall, 1-cycle registered outputs
// Ports:
//   d_clk, d_rst                        clock, async active-low reset
//   d_i_ce, d_i_instr, d_i_pc           instruction from fetch
//   d_i_stall, d_i_flush                hold / squash from downstream
//   d_i_wb_we, d_i_wb_addr, d_i_wb_data register write-back
//   d_o_*                               registered decode results for execute
//   d_o_stall                           combinational load-use stall to fetch
module instruction_decode #(
    parameter int IWIDTH   = instruction_decode_pkg::IWIDTH,
    parameter int PC_WIDTH = instruction_decode_pkg::PC_WIDTH,
    parameter int DWIDTH   = instruction_decode_pkg::DWIDTH,
    parameter int AWIDTH   = instruction_decode_pkg::AWIDTH
) (
    input  logic                d_clk,
    input  logic                d_rst,
    input  logic                d_i_ce,
    input  logic [IWIDTH-1:0]   d_i_instr,
    input  logic [PC_WIDTH-1:0] d_i_pc,
    input  logic                d_i_stall,
    input  logic                d_i_flush,
    input  logic                d_i_wb_we,
    input  logic [AWIDTH-1:0]   d_i_wb_addr,
    input  logic [DWIDTH-1:0]   d_i_wb_data,
    output logic                d_o_ce,
    output logic [PC_WIDTH-1:0] d_o_pc,
    output logic [5:0]          d_o_opcode,
    output logic [5:0]          d_o_funct,
    output logic [4:0]          d_o_shamt,
    output logic [AWIDTH-1:0]   d_o_rs_addr,
    output logic [AWIDTH-1:0]   d_o_rt_addr,
    output logic [AWIDTH-1:0]   d_o_rd_addr,
    output logic [DWIDTH-1:0]   d_o_rs_data,
    output logic [DWIDTH-1:0]   d_o_rt_data,
    output logic [DWIDTH-1:0]   d_o_imm,
    output logic [PC_WIDTH-1:0] d_o_jump_addr,
    output logic                d_o_reg_write,
    output logic                d_o_mem_read,
    output logic                d_o_mem_write,
    output logic                d_o_alu_src,
    output logic                d_o_branch,
    output logic                d_o_jump,
    output logic                d_o_illegal,
    output logic                d_o_stall
);
    import instruction_decode_pkg::*;

    typedef struct packed {
        logic                ce;
        logic [PC_WIDTH-1:0] pc;
        logic [5:0]          opcode;
        logic [5:0]          funct;
        logic [4:0]          shamt;
        logic [AWIDTH-1:0]   rs;
        logic [AWIDTH-1:0]   rt;
        logic [AWIDTH-1:0]   rd;
        logic [DWIDTH-1:0]   rs_data;
        logic [DWIDTH-1:0]   rt_data;
        logic [DWIDTH-1:0]   imm;
        logic [PC_WIDTH-1:0] jump_addr;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                alu_src;
        logic                branch;
        logic                jump;
        logic                illegal;
    } stage_t;

    stage_t            dec;
    stage_t            out_d;
    stage_t            out_q;
    logic [5:0]        op;
    logic [15:0]       imm16;
    logic [3:0]        pc_hi;
    logic [DWIDTH-1:0] rs_rd;
    logic [DWIDTH-1:0] rt_rd;
    logic              reads_rs;
    logic              reads_rt;
    logic              load_use;

    assign op    = d_i_instr[31:26];
    assign imm16 = d_i_instr[15:0];
    // Top nibble of pc+4: only a carry out of pc[27:2] can change it; wraps naturally at 2^32.
    assign pc_hi = d_i_pc[PC_WIDTH-1:28] + 4'(&d_i_pc[27:2]);

    register_file #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_rf (
        .clk_i     (d_clk),
        .rst_ni    (d_rst),
        .we_i      (d_i_wb_we),
        .waddr_i   (d_i_wb_addr),
        .wdata_i   (d_i_wb_data),
        .raddr_a_i (d_i_instr[25:21]),
        .raddr_b_i (d_i_instr[20:16]),
        .rdata_a_o (rs_rd),
        .rdata_b_o (rt_rd)
    );

    always_comb begin
        dec           = '0;
        dec.ce        = 1'b1;
        dec.pc        = d_i_pc;
        dec.opcode    = op;
        dec.funct     = d_i_instr[5:0];
        dec.shamt     = d_i_instr[10:6];
        dec.rs        = d_i_instr[25:21];
        dec.rt        = d_i_instr[20:16];
        dec.rd        = d_i_instr[20:16];
        dec.rs_data   = rs_rd;
        dec.rt_data   = rt_rd;
        dec.imm       = {{(DWIDTH-16){imm16[15]}}, imm16};
        dec.jump_addr = {pc_hi, d_i_instr[25:0], 2'b00};
        case (op)
            OP_RTYPE: begin
                dec.rd        = d_i_instr[15:11];
                dec.jump      = d_i_instr[5:0] == FUNCT_JR;
                dec.reg_write = d_i_instr[5:0] != FUNCT_JR;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: {dec.alu_src, dec.reg_write} = 2'b11;
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.imm                       = {{(DWIDTH-16){1'b0}}, imm16};
                {dec.alu_src, dec.reg_write} = 2'b11;
            end
            OP_LUI: begin
                dec.imm                       = {imm16, {(DWIDTH-16){1'b0}}};
                {dec.alu_src, dec.reg_write} = 2'b11;
            end
            OP_LW:         {dec.mem_read, dec.alu_src, dec.reg_write} = 3'b111;
            OP_SW:         {dec.mem_write, dec.alu_src} = 2'b11;
            OP_BEQ, OP_BNE: dec.branch = 1'b1;
            OP_J:          dec.jump = 1'b1;
            OP_JAL: begin
                dec.rd                     = REG_RA;
                {dec.jump, dec.reg_write} = 2'b11;
            end
            default:       dec.illegal = 1'b1;
        endcase
        dec.reg_write = dec.reg_write && dec.rd != '0;
    end

    assign reads_rs  = !(op inside {OP_J, OP_JAL, OP_LUI});
    assign reads_rt  = op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
    assign load_use  = out_q.ce && out_q.mem_read && out_q.rt != '0 && d_i_ce &&
                       ((reads_rs && dec.rs == out_q.rt) || (reads_rt && dec.rt == out_q.rt));
    assign d_o_stall = load_use;

    // Flush beats stall; a bubble (load-use or idle) keeps data fields but drops valid and controls.
    always_comb begin
        out_d = out_q;
        if (d_i_flush || (!d_i_stall && (load_use || !d_i_ce)))
            {out_d.ce, out_d.reg_write, out_d.mem_read, out_d.mem_write,
             out_d.alu_src, out_d.branch, out_d.jump, out_d.illegal} = '0;
        else if (!d_i_stall)
            out_d = dec;
    end

    always_ff @(posedge d_clk or negedge d_rst)
        if (!d_rst) out_q <= '0;
        else        out_q <= out_d;

    assign d_o_ce        = out_q.ce;
    assign d_o_pc        = out_q.pc;
    assign d_o_opcode    = out_q.opcode;
    assign d_o_funct     = out_q.funct;
    assign d_o_shamt     = out_q.shamt;
    assign d_o_rs_addr   = out_q.rs;
    assign d_o_rt_addr   = out_q.rt;
    assign d_o_rd_addr   = out_q.rd;
    assign d_o_rs_data   = out_q.rs_data;
    assign d_o_rt_data   = out_q.rt_data;
    assign d_o_imm       = out_q.imm;
    assign d_o_jump_addr = out_q.jump_addr;
    assign d_o_reg_write = out_q.reg_write;
    assign d_o_mem_read  = out_q.mem_read;
    assign d_o_mem_write = out_q.mem_write;
    assign d_o_alu_src   = out_q.alu_src;
    assign d_o_branch    = out_q.branch;
    assign d_o_jump      = out_q.jump;
    assign d_o_illegal   = out_q.illegal;
endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
Second pipeline stage of the MIPS core, directly downstream of instruction fetch. Captures each instruction and PC that fetch qualifies with its output enable, and decodes the opcode, funct and register fields. Reads operands from an internal 32x32 register file that has a write-back port. Detects load-use hazards and registers operands plus control signals for the execute stage with one cycle of latency.

Parameters:
IWIDTH, 32, instruction width
PC_WIDTH, 32, program counter width
DWIDTH, 32, register data width
AWIDTH, 5, register address width

Ports:
d_clk  in  1  clock
d_rst  in  1  async active-low reset
d_i_ce  in  1  instruction valid; driven by fetch f_o_ce
d_i_instr  in  IWIDTH  instruction from fetch
d_i_pc  in  PC_WIDTH  address of d_i_instr
d_i_stall  in  1  downstream hold request
d_i_flush  in  1  squash (taken branch or jump)
d_i_wb_we  in  1  write-back enable
d_i_wb_addr  in  AWIDTH  write-back register
d_i_wb_data  in  DWIDTH  write-back data
d_o_ce  out  1  outputs valid
d_o_pc  out  PC_WIDTH  PC of decoded instruction
d_o_opcode  out  6  instr[31:26]
d_o_funct  out  6  instr[5:0]
d_o_shamt  out  5  instr[10:6]
d_o_rs_addr, d_o_rt_addr  out  AWIDTH  source registers
d_o_rd_addr  out  AWIDTH  destination (rd, rt or 31)
d_o_rs_data, d_o_rt_data  out  DWIDTH  operands
d_o_imm  out  DWIDTH  extended immediate
d_o_jump_addr  out  PC_WIDTH  {d_i_pc+4 [31:28], instr[25:0], 2'b00}
d_o_reg_write, d_o_mem_read, d_o_mem_write, d_o_alu_src, d_o_branch, d_o_jump  out  1 each  control
d_o_illegal  out  1  unknown opcode
d_o_stall  out  1  combinational load-use stall to fetch

Interface decision: one clock, d_clk; reset d_rst is asynchronous and active-low.

Behaviour:
- Reset (d_rst=0, async):
  - All d_o_* registers clear to 0.
  - All 32 registers in the register file clear to 0.
  - d_o_stall is 0.
- Latency: outputs register on the posedge after d_i_ce=1, so latency is 1 cycle.
- Priority at each posedge: flush > stall > load-use bubble > normal capture > idle.
  - Flush: d_o_ce and all control bits go to 0. Data fields are don't-care.
  - d_i_stall=1 (no flush): all outputs hold, including d_o_ce. The register file still accepts a write-back.
  - Load-use: if registered d_o_ce=1, d_o_mem_read=1, d_o_rt_addr!=0, d_i_ce=1, and the incoming instruction reads that register, then:
    - d_o_stall=1 combinationally in the same cycle.
    - The next state is a bubble: d_o_ce=0 and controls 0.
    - Upstream re-presents the same instruction the following cycle.
  - "Reads" means rs for all types except j/jal/lui, and rt for R-type, sw, beq and bne.
  - d_i_ce=0: d_o_ce goes to 0 and controls go to 0.
- Decode table (opcode, with actions):
  - 0x00 R-type: dest rd; reg_write=1 unless funct=0x08 (jr); jr sets jump=1.
  - 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu: sign-extended imm, alu_src=1, dest rt, reg_write=1.
  - 0x0C andi, 0x0D ori, 0x0E xori: zero-extended imm, alu_src=1, dest rt, reg_write=1.
  - 0x0F lui: imm={instr[15:0],16'h0}, alu_src=1, dest rt, reg_write=1.
  - 0x23 lw: mem_read=1, alu_src=1, dest rt, reg_write=1, sign-extended imm.
  - 0x2B sw: mem_write=1, alu_src=1, sign-extended imm.
  - 0x04 beq, 0x05 bne: branch=1, sign-extended imm.
  - 0x02 j: jump=1.
  - 0x03 jal: jump=1, reg_write=1, dest 31.
  - Any other opcode: illegal=1, all controls 0, d_o_ce still 1.
- Destination 0: reg_write is forced to 0 when the destination register is 0.
- Register file:
  - Synchronous write on posedge when d_i_wb_we=1 and d_i_wb_addr!=0; writes to register 0 are ignored.
  - Combinational read; register 0 always reads 0.
  - Write-back bypass: a read of the address being written in the same cycle returns d_i_wb_data.
- PC arithmetic: d_i_pc+4 wraps modulo 2^PC_WIDTH.
- Reset mid-operation: any bubble or stall is abandoned; the first valid instruction after reset decodes normally.

Decomposition:
- Shared header (alongside existing width defines), holding:
  - `IWIDTH, `PC_WIDTH, `DWIDTH, `AWIDTH
  - opcode defines OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL
  - FUNCT_JR
  - REG_RA=31
- One sub-module, register_file:
  - 32xDWIDTH storage
  - two combinational read ports with write bypass
  - one write port
  - async active-low reset

Test Plan:
- Reset, then load r1=5 via write-back. Present addi r2,r1,-3 (0x2022FFFD) with ce=1 -> next cycle d_o_ce=1, rs_data=5, imm=0xFFFFFFFD, rd_addr=2, reg_write=1, alu_src=1.
- ori r3,r0,0x8000 -> imm=0x00008000 (zero-extended). lui r4,0x1234 -> imm=0x12340000.
- lw r5,0(r1), then add r6,r5,r1 on consecutive cycles -> d_o_stall=1 during the add cycle, one bubble (d_o_ce=0), then the add decodes with d_o_ce=1.
- Write-back r7=0xDEADBEEF in the same cycle as decoding add r8,r7,r7 -> rs_data=rt_data=0xDEADBEEF. A write-back to r0 -> r0 still reads 0.
- d_i_stall=1 for 3 cycles with new instructions on the input -> outputs unchanged. Assert d_i_flush alongside stall -> d_o_ce=0 next cycle.
- jal 0x0000010 at pc=0xF0000000 -> jump=1, rd_addr=31, jump_addr=0xF0000040. Opcode 0x3F -> illegal=1 and reg_write=0. Drop d_rst mid-stream -> all outputs 0 immediately.
